reg_dump_unit: RTL

Debug-unit block that reads the whole MIPS register file out of the ID stage after a halt and streams it to the UART transmitter. It drives the ID stage's debug read index (`i_reg_read_from_debug_unit`) and consumes the returned word (`o_reg_data_to_debug_unit`), acting as the reader on that port. It serializes each register as bytes, most significant byte first, through a start/done handshake with the UART TX.

---
 rtl/reg_dump_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_dump_unit.sv
// ============================================================================
// Module      : reg_dump_unit
// Description : Reads the register file through the ID debug port after a
//               halt and streams each word to the UART TX, MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_unit #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_UART_DATA = 8,
  parameter int CANT_BITS_INDEX     = $clog2(CANT_REGISTROS)
) (
  input  logic                           i_clock,
  input  logic                           i_soft_reset,
  input  logic                           i_start,
  input  logic [CANT_BITS_REGISTROS-1:0] i_reg_data,
  input  logic                           i_tx_done,
  output logic [CANT_BITS_INDEX-1:0]     o_reg_read,
  output logic [CANT_BITS_UART_DATA-1:0] o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int BYTES      = CANT_BITS_REGISTROS / CANT_BITS_UART_DATA;
  localparam int BYTE_CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BYTE_CNT_W-1:0]      LAST_BYTE  = BYTE_CNT_W'(BYTES - 1);
  localparam logic [CANT_BITS_INDEX-1:0] LAST_INDEX = CANT_BITS_INDEX'(CANT_REGISTROS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t                         state_q;
  logic [CANT_BITS_INDEX-1:0]     index_q;
  logic [BYTE_CNT_W-1:0]          byte_cnt_q;
  logic [CANT_BITS_REGISTROS-1:0] shift_q;
  logic                           tx_start_q;
  logic                           done_q;

  // Strobes are raised on the edge that enters SEND/FINISH so they line up
  // exactly with those states while staying registered.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q    <= ST_SELECT;
            index_q    <= '0;
            byte_cnt_q <= '0;
          end
        end
        ST_SELECT: begin
          shift_q    <= i_reg_data;
          tx_start_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_cnt_q < LAST_BYTE) begin
              shift_q    <= shift_q << CANT_BITS_UART_DATA;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              tx_start_q <= 1'b1;
              state_q    <= ST_SEND;
            end else if (index_q < LAST_INDEX) begin
              index_q    <= index_q + 1'b1;
              byte_cnt_q <= '0;
              state_q    <= ST_SELECT;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_reg_read = index_q;
  assign o_tx_data  = shift_q[CANT_BITS_REGISTROS-1 -: CANT_BITS_UART_DATA];
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;

endmodule

`default_nettype wire
